// File: rtl/mmio_csr_bank_if.sv
// Host MMIO request/response bundle for mmio_csr_bank.
// The host drives requests through the master modport; the register bank answers through the slave modport.
interface mmio_csr_bank_if #(
    parameter int TID_W = 9
);
    logic             mmio_wr_valid;
    logic             mmio_rd_valid;
    logic [15:0]      mmio_addr;
    logic [TID_W-1:0] mmio_tid;
    logic [63:0]      mmio_wr_data;
    logic             mmio_len32;
    logic             rd_rsp_valid;
    logic [TID_W-1:0] rd_rsp_tid;
    logic [63:0]      rd_rsp_data;

    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data, mmio_len32,
        input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data
    );

    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wr_data, mmio_len32,
        output rd_rsp_valid, rd_rsp_tid, rd_rsp_data
    );
endinterface

// File: rtl/mmio_csr_bank.sv
// MMIO CSR bank: AFU DFH/ID words, NUM_RW user registers, NUM_RO status slots, access counters.
// Define MMIO_ACC32_EN to enable 32-bit (mmio_len32) half-register accesses.
module mmio_csr_bank #(
    parameter int             NUM_RW    = 4,
    parameter int             NUM_RO    = 4,
    parameter logic [15:0]    BASE_ADDR = 16'h0020,
    parameter logic [127:0]   AFU_ID    = 128'h0,
    parameter int             RD_LAT    = 1,
    parameter int             TID_W     = 9
) (
    input  logic                                      clk,
    input  logic                                      rst,
    mmio_csr_bank_if.slave                            bus,
    output logic [64*NUM_RW-1:0]                      reg_q,
    output logic [NUM_RW-1:0]                         reg_wr_pulse,
    input  logic [64*(NUM_RO > 0 ? NUM_RO : 1)-1:0]   status_in
);

    localparam logic [63:0] DFH = {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    logic [63:0]       regs [NUM_RW];
    logic [31:0]       wr_count;
    logic [31:0]       rd_count;
    logic [14:0]       addr_hi;
    logic [14:0]       slot;
    logic              in_user;
    logic              half_acc;
    logic              acc_ok;
    logic [63:0]       rd_word;
    logic [63:0]       rd_data;
    logic [NUM_RW-1:0] wr_sel;

    logic              pipe_valid [RD_LAT];
    logic [TID_W-1:0]  pipe_tid   [RD_LAT];
    logic [63:0]       pipe_data  [RD_LAT];

`ifdef MMIO_ACC32_EN
    assign half_acc = bus.mmio_len32;
`else
    logic unused_len32;
    assign unused_len32 = bus.mmio_len32;
    assign half_acc     = 1'b0;
`endif

    // Decode on 64-bit word granularity; bit 0 only selects the half of a 32-bit access.
    assign addr_hi = bus.mmio_addr[15:1];
    assign slot    = addr_hi - BASE_ADDR[15:1];
    assign in_user = (addr_hi >= BASE_ADDR[15:1]);
    assign acc_ok  = half_acc || !bus.mmio_addr[0];

    for (genvar g = 0; g < NUM_RW; g++) begin : g_regq
        assign reg_q[64*g +: 64] = regs[g];
    end

    always_comb begin
        rd_word = '0;
        case (addr_hi)
            15'd0:   rd_word = DFH;
            15'd1:   rd_word = AFU_ID[63:0];
            15'd2:   rd_word = AFU_ID[127:64];
            15'd5:   rd_word = {wr_count, rd_count};
            default: begin
                if (in_user) begin
                    for (int i = 0; i < NUM_RW; i++) begin
                        if (slot == 15'(i)) rd_word = regs[i];
                    end
                    for (int j = 0; j < NUM_RO; j++) begin
                        if (slot == 15'(NUM_RW + j)) rd_word = status_in[64*j +: 64];
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_data = '0;
        if (half_acc) begin
            rd_data = bus.mmio_addr[0] ? {32'h0, rd_word[63:32]} : {32'h0, rd_word[31:0]};
        end else if (!bus.mmio_addr[0]) begin
            rd_data = rd_word;
        end
    end

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            wr_sel[i] = bus.mmio_wr_valid && acc_ok && in_user && (slot == 15'(i));
        end
    end

    // The pulse is registered alongside the data so it coincides with the new reg_q value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
            reg_wr_pulse <= '0;
            wr_count     <= '0;
            rd_count     <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (wr_sel[i]) begin
                    if (half_acc && bus.mmio_addr[0]) regs[i][63:32] <= bus.mmio_wr_data[31:0];
                    else if (half_acc)                regs[i][31:0]  <= bus.mmio_wr_data[31:0];
                    else                              regs[i]        <= bus.mmio_wr_data;
                end
            end
            reg_wr_pulse <= wr_sel;
            if (bus.mmio_wr_valid) wr_count <= wr_count + 32'd1;
            if (bus.mmio_rd_valid) rd_count <= rd_count + 32'd1;
        end
    end

    // Tid/data only advance with a valid beat, so the last stage holds its value between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_tid[s]   <= '0;
                pipe_data[s]  <= '0;
            end
        end else begin
            pipe_valid[0] <= bus.mmio_rd_valid;
            if (bus.mmio_rd_valid) begin
                pipe_tid[0]  <= bus.mmio_tid;
                pipe_data[0] <= rd_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                if (pipe_valid[s-1]) begin
                    pipe_tid[s]  <= pipe_tid[s-1];
                    pipe_data[s] <= pipe_data[s-1];
                end
            end
        end
    end

    assign bus.rd_rsp_valid = pipe_valid[RD_LAT-1];
    assign bus.rd_rsp_tid   = pipe_tid[RD_LAT-1];
    assign bus.rd_rsp_data  = pipe_data[RD_LAT-1];

endmodule

// File: tb/tb_mmio_csr_bank.sv
// Self-checking bench for mmio_csr_bank: directed scenarios plus randomized traffic checked
// against an address-map reference model (MMIO_ACC32_EN adds the 32-bit access scenario).
module tb_mmio_csr_bank;

    localparam int           NUM_RW    = 4;
    localparam int           NUM_RO    = 4;
    localparam logic [15:0]  BASE_ADDR = 16'h0020;
    localparam logic [63:0]  ID_LO     = 64'h89AB_CDEF_5A5A_5A5A;
    localparam logic [63:0]  ID_HI     = 64'hA5A5_A5A5_0123_4567;
    localparam int           RD_LAT    = 3;
    localparam int           TID_W     = 9;
    localparam logic [63:0]  DFH_EXP   = 64'h1000_0100_0000_0000;

    typedef struct {
        int               c;
        logic [TID_W-1:0] t;
        logic [63:0]      d;
    } rsp_t;

    logic clk;
    logic rst;
    logic [64*NUM_RW-1:0] reg_q;
    logic [NUM_RW-1:0]    reg_wr_pulse;
    logic [64*NUM_RO-1:0] status_in;

    mmio_csr_bank_if #(.TID_W(TID_W)) bus ();

    mmio_csr_bank #(
        .NUM_RW(NUM_RW), .NUM_RO(NUM_RO), .BASE_ADDR(BASE_ADDR),
        .AFU_ID({ID_HI, ID_LO}), .RD_LAT(RD_LAT), .TID_W(TID_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [63:0]       m_regs [NUM_RW];
    logic [31:0]       m_wr;
    logic [31:0]       m_rd;
    logic [NUM_RW-1:0] exp_pulse;
    rsp_t              exp_rsp [$];
    rsp_t              obs_rsp [$];

    // Reference model: the address map written out directly as arithmetic on word addresses.
    function automatic logic [63:0] model_read(input logic [15:0] a, input bit l32);
        int          ea;
        int          k;
        bit          half;
        logic [63:0] w;
        ea = int'(a) & 32'hFFFE;
        w  = 64'h0;
`ifdef MMIO_ACC32_EN
        half = l32;
`else
        half = 1'b0 && l32;
`endif
        if (ea == 0)       w = DFH_EXP;
        else if (ea == 2)  w = ID_LO;
        else if (ea == 4)  w = ID_HI;
        else if (ea == 10) w = {m_wr, m_rd};
        else if (ea >= int'(BASE_ADDR)) begin
            k = (ea - int'(BASE_ADDR)) / 2;
            if (k < NUM_RW) w = m_regs[k];
            else if (k < NUM_RW + NUM_RO) w = status_in[64*(k-NUM_RW) +: 64];
        end
        if (half) return a[0] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
        return a[0] ? 64'h0 : w;
    endfunction

    function automatic logic [NUM_RW-1:0] model_write(input logic [15:0] a, input logic [63:0] d, input bit l32);
        int                ea;
        int                k;
        bit                half;
        logic [NUM_RW-1:0] p;
        p    = '0;
        ea   = int'(a) & 32'hFFFE;
        m_wr = m_wr + 32'd1;
`ifdef MMIO_ACC32_EN
        half = l32;
`else
        half = 1'b0 && l32;
`endif
        if (!half && a[0]) return p;
        if (ea < int'(BASE_ADDR)) return p;
        k = (ea - int'(BASE_ADDR)) / 2;
        if (k >= NUM_RW) return p;
        if (half && a[0]) m_regs[k][63:32] = d[31:0];
        else if (half)    m_regs[k][31:0]  = d[31:0];
        else              m_regs[k]        = d;
        p[k] = 1'b1;
        return p;
    endfunction

    function automatic logic [64*NUM_RW-1:0] model_regq();
        logic [64*NUM_RW-1:0] v;
        for (int i = 0; i < NUM_RW; i++) v[64*i +: 64] = m_regs[i];
        return v;
    endfunction

    task automatic do_cycle(input bit wr, input bit rd, input logic [15:0] a,
                            input logic [TID_W-1:0] t, input logic [63:0] d, input bit l32);
        rsp_t e;
        rsp_t o;
        bus.mmio_wr_valid = wr;
        bus.mmio_rd_valid = rd;
        bus.mmio_addr     = a;
        bus.mmio_tid      = t;
        bus.mmio_wr_data  = d;
        bus.mmio_len32    = l32;
        if (rd) begin
            e.c = cyc + RD_LAT;
            e.t = t;
            e.d = model_read(a, l32);
            exp_rsp.push_back(e);
            m_rd = m_rd + 32'd1;
        end
        exp_pulse = wr ? model_write(a, d, l32) : '0;
        @(posedge clk);
        #1;
        cyc++;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        if (bus.rd_rsp_valid) begin
            o.c = cyc;
            o.t = bus.rd_rsp_tid;
            o.d = bus.rd_rsp_data;
            obs_rsp.push_back(o);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, 1'b0, 16'h0, '0, 64'h0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc += 2;
        rst = 1'b0;
        for (int i = 0; i < NUM_RW; i++) m_regs[i] = 64'h0;
        m_wr = 32'h0;
        m_rd = 32'h0;
        exp_pulse = '0;
        exp_rsp.delete();
    endtask

    task automatic test_reset();
        int s;
        do_reset();
        obs_rsp.delete();
        tests++; if (bus.rd_rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.rd_rsp_valid); end
        tests++; if (bus.rd_rsp_tid !== '0) begin fails++; $display("[TB] FAIL reset_tid: got %h expected 0", bus.rd_rsp_tid); end
        tests++; if (bus.rd_rsp_data !== 64'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 0", bus.rd_rsp_data); end
        tests++; if (reg_q !== '0) begin fails++; $display("[TB] FAIL reset_regq: got %h expected 0", reg_q); end
        tests++; if (reg_wr_pulse !== '0) begin fails++; $display("[TB] FAIL reset_pulse: got %b expected 0", reg_wr_pulse); end
        s = cyc;
        do_cycle(1'b0, 1'b1, 16'h000A, TID_W'(3), 64'h0, 1'b0);
        idle(RD_LAT + 1);
        tests++;
        if (obs_rsp.size() != 1) begin
            fails++; $display("[TB] FAIL reset_counter_rsp_count: got %0d expected 1", obs_rsp.size());
        end else begin
            tests++; if (obs_rsp[0].d !== 64'h0) begin fails++; $display("[TB] FAIL reset_counters: got %h expected 0", obs_rsp[0].d); end
            tests++; if (obs_rsp[0].c != s + RD_LAT) begin fails++; $display("[TB] FAIL reset_counter_latency: got cycle %0d expected %0d", obs_rsp[0].c, s + RD_LAT); end
        end
    endtask

    task automatic test_id_reads();
        logic [63:0]  exp_d [3];
        logic [15:0]  adr   [3];
        int s;
        exp_d = '{DFH_EXP, ID_LO, ID_HI};
        adr   = '{16'h0000, 16'h0002, 16'h0004};
        obs_rsp.delete();
        s = cyc;
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b1, adr[k], TID_W'(5 + k), 64'h0, 1'b0);
        idle(RD_LAT + 1);
        tests++;
        if (obs_rsp.size() != 3) begin fails++; $display("[TB] FAIL id_rsp_count: got %0d expected 3", obs_rsp.size()); end
        for (int k = 0; k < 3 && k < obs_rsp.size(); k++) begin
            tests++; if (obs_rsp[k].c != s + k + RD_LAT) begin fails++; $display("[TB] FAIL id_latency[%0d]: got cycle %0d expected %0d", k, obs_rsp[k].c, s + k + RD_LAT); end
            tests++; if (obs_rsp[k].t !== TID_W'(5 + k)) begin fails++; $display("[TB] FAIL id_tid[%0d]: got %0d expected %0d", k, obs_rsp[k].t, 5 + k); end
            tests++; if (obs_rsp[k].d !== exp_d[k]) begin fails++; $display("[TB] FAIL id_data[%0d]: got %h expected %h", k, obs_rsp[k].d, exp_d[k]); end
        end
    endtask

    task automatic test_write_readback();
        logic [63:0] v;
        int s;
        v = 64'hDEAD_BEEF_0123_4567;
        obs_rsp.delete();
        do_cycle(1'b1, 1'b0, 16'h0022, '0, v, 1'b0);
        tests++; if (reg_q[127:64] !== v) begin fails++; $display("[TB] FAIL wr_regq1: got %h expected %h", reg_q[127:64], v); end
        tests++; if (reg_wr_pulse !== 4'b0010) begin fails++; $display("[TB] FAIL wr_pulse: got %b expected 0010", reg_wr_pulse); end
        idle(1);
        tests++; if (reg_wr_pulse !== 4'b0000) begin fails++; $display("[TB] FAIL wr_pulse_single: got %b expected 0000", reg_wr_pulse); end
        tests++; if (reg_q !== model_regq()) begin fails++; $display("[TB] FAIL wr_regq_all: got %h expected %h", reg_q, model_regq()); end
        s = cyc;
        do_cycle(1'b0, 1'b1, 16'h0022, TID_W'(9'h1AB), 64'h0, 1'b0);
        idle(RD_LAT);
        tests++;
        if (obs_rsp.size() != 1) begin
            fails++; $display("[TB] FAIL wr_readback_count: got %0d expected 1", obs_rsp.size());
        end else begin
            tests++; if (obs_rsp[0].d !== v) begin fails++; $display("[TB] FAIL wr_readback: got %h expected %h", obs_rsp[0].d, v); end
            tests++; if (obs_rsp[0].c != s + RD_LAT) begin fails++; $display("[TB] FAIL wr_readback_latency: got %0d expected %0d", obs_rsp[0].c, s + RD_LAT); end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        obs_rsp.delete();
        exp_rsp.delete();
        s = cyc;
        for (int k = 0; k < 4; k++)
            do_cycle(1'b0, 1'b1, 16'(BASE_ADDR + 16'(2 * $urandom_range(0, 7))), TID_W'(k + 1), 64'h0, 1'b0);
        idle(RD_LAT + 2);
        tests++;
        if (obs_rsp.size() != 4) begin fails++; $display("[TB] FAIL b2b_count: got %0d expected 4", obs_rsp.size()); end
        for (int k = 0; k < 4 && k < obs_rsp.size(); k++) begin
            tests++; if (obs_rsp[k].c != s + RD_LAT + k) begin fails++; $display("[TB] FAIL b2b_cycle[%0d]: got %0d expected %0d", k, obs_rsp[k].c, s + RD_LAT + k); end
            tests++; if (obs_rsp[k].t !== TID_W'(k + 1)) begin fails++; $display("[TB] FAIL b2b_tid[%0d]: got %0d expected %0d", k, obs_rsp[k].t, k + 1); end
            tests++; if (obs_rsp[k].d !== exp_rsp[k].d) begin fails++; $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, obs_rsp[k].d, exp_rsp[k].d); end
        end
    endtask

    task automatic test_unmapped_writes();
        do_reset();
        obs_rsp.delete();
        do_cycle(1'b1, 1'b0, 16'h0000, '0, {$urandom, $urandom}, 1'b0);
        tests++; if (reg_wr_pulse !== '0) begin fails++; $display("[TB] FAIL unmapped_pulse_dfh: got %b expected 0", reg_wr_pulse); end
        do_cycle(1'b1, 1'b0, 16'h0100, '0, {$urandom, $urandom}, 1'b0);
        tests++; if (reg_wr_pulse !== '0) begin fails++; $display("[TB] FAIL unmapped_pulse_0100: got %b expected 0", reg_wr_pulse); end
        tests++; if (reg_q !== '0) begin fails++; $display("[TB] FAIL unmapped_regq: got %h expected 0", reg_q); end
        do_cycle(1'b0, 1'b1, 16'h000A, TID_W'(9'h055), 64'h0, 1'b0);
        idle(RD_LAT);
        tests++;
        if (obs_rsp.size() != 1) begin
            fails++; $display("[TB] FAIL counters_count: got %0d expected 1", obs_rsp.size());
        end else begin
            tests++; if (obs_rsp[0].d !== 64'h0000_0002_0000_0000) begin fails++; $display("[TB] FAIL counters_data: got %h expected 0000000200000000", obs_rsp[0].d); end
        end
    endtask

    task automatic test_reset_flush();
        do_reset();
        do_cycle(1'b1, 1'b0, 16'h0024, '0, {$urandom, $urandom} | 64'h1, 1'b0);
        obs_rsp.delete();
        do_cycle(1'b0, 1'b1, 16'h0024, TID_W'(9), 64'h0, 1'b0);
        do_reset();
        idle(RD_LAT + 2);
        tests++; if (obs_rsp.size() != 0) begin fails++; $display("[TB] FAIL flush_rsp: got %0d responses expected 0", obs_rsp.size()); end
        tests++; if (reg_q !== '0) begin fails++; $display("[TB] FAIL flush_regq: got %h expected 0", reg_q); end
        tests++; if (bus.rd_rsp_tid !== '0) begin fails++; $display("[TB] FAIL flush_tid: got %h expected 0", bus.rd_rsp_tid); end
        tests++; if (bus.rd_rsp_data !== 64'h0) begin fails++; $display("[TB] FAIL flush_data: got %h expected 0", bus.rd_rsp_data); end
    endtask

    task automatic test_random();
        logic [15:0] misc [10];
        logic [15:0] a;
        misc = '{16'h0000, 16'h0001, 16'h0002, 16'h0004, 16'h0005, 16'h0006,
                 16'h000A, 16'h000B, 16'h0030, 16'h0100};
        do_reset();
        obs_rsp.delete();
        for (int n = 0; n < 300; n++) begin
            if (n % 50 == 0)
                for (int j = 0; j < NUM_RO; j++) status_in[64*j +: 64] = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 7) a = BASE_ADDR + 16'($urandom_range(0, 15));
            else                          a = misc[$urandom_range(0, 9)];
            do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0), a,
                     TID_W'($urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            tests++; if (reg_q !== model_regq()) begin fails++; $display("[TB] FAIL rand_regq@%0d: got %h expected %h", cyc, reg_q, model_regq()); end
            tests++; if (reg_wr_pulse !== exp_pulse) begin fails++; $display("[TB] FAIL rand_pulse@%0d: got %b expected %b", cyc, reg_wr_pulse, exp_pulse); end
        end
        idle(RD_LAT + 1);
        tests++;
        if (obs_rsp.size() != exp_rsp.size()) begin fails++; $display("[TB] FAIL rand_rsp_count: got %0d expected %0d", obs_rsp.size(), exp_rsp.size()); end
        for (int k = 0; k < obs_rsp.size() && k < exp_rsp.size(); k++) begin
            tests++;
            if (obs_rsp[k].c != exp_rsp[k].c || obs_rsp[k].t !== exp_rsp[k].t || obs_rsp[k].d !== exp_rsp[k].d) begin
                fails++;
                $display("[TB] FAIL rand_rsp[%0d]: got c=%0d t=%h d=%h expected c=%0d t=%h d=%h", k,
                         obs_rsp[k].c, obs_rsp[k].t, obs_rsp[k].d, exp_rsp[k].c, exp_rsp[k].t, exp_rsp[k].d);
            end
        end
    endtask

`ifdef MMIO_ACC32_EN
    task automatic test_acc32();
        do_reset();
        obs_rsp.delete();
        do_cycle(1'b1, 1'b0, 16'h0021, '0, 64'hABCD_0000_1111_2222, 1'b1);
        tests++; if (reg_q[63:0] !== 64'h1111_2222_0000_0000) begin fails++; $display("[TB] FAIL acc32_regq0: got %h expected 1111222200000000", reg_q[63:0]); end
        tests++; if (reg_wr_pulse !== 4'b0001) begin fails++; $display("[TB] FAIL acc32_pulse: got %b expected 0001", reg_wr_pulse); end
        do_cycle(1'b1, 1'b0, 16'h0023, '0, 64'h5555_6666_7777_8888, 1'b0);
        tests++; if (reg_wr_pulse !== 4'b0000) begin fails++; $display("[TB] FAIL acc32_odd64_pulse: got %b expected 0000", reg_wr_pulse); end
        do_cycle(1'b0, 1'b1, 16'h0021, TID_W'(4), 64'h0, 1'b1);
        idle(RD_LAT);
        tests++;
        if (obs_rsp.size() != 1) begin
            fails++; $display("[TB] FAIL acc32_rsp_count: got %0d expected 1", obs_rsp.size());
        end else begin
            tests++; if (obs_rsp[0].d !== 64'h0000_0000_1111_2222) begin fails++; $display("[TB] FAIL acc32_read: got %h expected 0000000011112222", obs_rsp[0].d); end
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_addr     = 16'h0;
        bus.mmio_tid      = '0;
        bus.mmio_wr_data  = 64'h0;
        bus.mmio_len32    = 1'b0;
        for (int j = 0; j < NUM_RO; j++) status_in[64*j +: 64] = {$urandom, $urandom};
        test_reset();
        test_id_reads();
        test_write_readback();
        test_back_to_back();
        test_unmapped_writes();
        test_reset_flush();
        test_random();
`ifdef MMIO_ACC32_EN
        test_acc32();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
